mod_147_rx_status: RTL and testbench

- Upstream neighbour of the Clause 147 link monitor. It produces the `pcs_status` and `loc_rcv_status` inputs that the link monitor consumes.
- It watches the decoded 4B/5B receive symbol stream from the PCS receive path.
- It qualifies code-group lock using good and bad symbol counters.
- It runs a receive-activity timeout so a dead line is reported promptly.

---
 rtl/mod_147_rx_status_pkg.sv | 27 ++
 rtl/mod_147_rx_act_timer.sv | 40 ++++
 rtl/mod_147_rx_status.sv | 174 +++++++++++++++++
 tb/tb_mod_147_rx_status.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_147_rx_status_pkg.sv
// Shared Clause 147 receive-status constants, state encodings and default thresholds.
// Imported by the receive-status top and its activity timer.
package mod_147_rx_status_pkg;

  localparam logic OK      = 1'b0;
  localparam logic NOT_OK  = 1'b1;
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CHECK   = 2'd1,
    LOCKED  = 2'd2,
    UNUSED3 = 2'd3
  } rx_state_e;

  localparam int GOOD_THRESH_DEF = 16;
  localparam int BAD_THRESH_DEF  = 4;
  localparam int WINDOW_DEF      = 64;
  localparam int ACT_TIMEOUT_DEF = 1024;

  // One spare bit so a counter can hold its own threshold.
  function automatic int cnt_width(input int thresh);
    return $clog2(thresh) + 1;
  endfunction

endpackage

// File: rtl/mod_147_rx_act_timer.sv
// Saturating receive-activity counter; flags the edge on which the line goes idle.
// expire_o stays high while saturated, so the consumer keeps hunting until a strobe.
module mod_147_rx_act_timer
  import mod_147_rx_status_pkg::*;
#(
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic strobe_i,
  output logic expire_o
);

  localparam int AW = cnt_width(ACT_TIMEOUT);
  localparam logic [AW-1:0] LIMIT = AW'(ACT_TIMEOUT);

  logic [AW-1:0] act_q;
  logic [AW-1:0] act_d;

  always_comb begin
    act_d = act_q;
    if (clr_i || strobe_i) begin
      act_d = '0;
    end else if (act_q != LIMIT) begin
      act_d = act_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end

  assign expire_o = (act_d == LIMIT);

endmodule

// File: rtl/mod_147_rx_status.sv
// Clause 147 receive status: code-group lock qualification and activity timeout.
// Produces pcs_status and loc_rcv_status for the link monitor.
module mod_147_rx_status
  import mod_147_rx_status_pkg::*;
#(
  parameter int GOOD_THRESH = GOOD_THRESH_DEF,
  parameter int BAD_THRESH  = BAD_THRESH_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pma_reset,
  input  logic       link_control,
  input  logic       rx_sym_strobe,
  input  logic       rx_sym_invalid,
  output logic       pcs_status,
  output logic       loc_rcv_status,
  output logic [1:0] rx_status_state
);

  localparam int GW = cnt_width(GOOD_THRESH);
  localparam int BW = cnt_width(BAD_THRESH);
  localparam int WW = cnt_width(WINDOW);

  localparam logic [GW-1:0] GOOD_LIM = GW'(GOOD_THRESH);
  localparam logic [BW-1:0] BAD_LIM  = BW'(BAD_THRESH);
  localparam logic [WW-1:0] WIN_LIM  = WW'(WINDOW);

  rx_state_e     state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [WW-1:0] win_q, win_d;
  logic          pcs_q, pcs_d;
  logic          loc_q, loc_d;

  logic          force_clr;
  logic          act_expire;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;
  logic [WW-1:0] win_inc;

  assign force_clr = pma_reset | (link_control == DISABLE);

  mod_147_rx_act_timer #(
    .ACT_TIMEOUT(ACT_TIMEOUT)
  ) u_act_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (force_clr),
    .strobe_i (rx_sym_strobe),
    .expire_o (act_expire)
  );

  assign good_inc = good_q + 1'b1;
  assign bad_inc  = bad_q + 1'b1;
  assign win_inc  = win_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      win_q   <= '0;
      pcs_q   <= NOT_OK;
      loc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      win_q   <= win_d;
      pcs_q   <= pcs_d;
      loc_q   <= loc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    win_d   = win_q;
    if (force_clr || act_expire) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
      win_d   = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (rx_sym_strobe && !rx_sym_invalid) begin
            good_d  = GW'(1);
            state_d = CHECK;
            if (GW'(1) >= GOOD_LIM) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
              win_d   = '0;
            end
          end
        end
        CHECK: begin
          if (rx_sym_strobe) begin
            if (rx_sym_invalid) begin
              good_d  = '0;
              state_d = HUNT;
            end else if (good_inc >= GOOD_LIM) begin
              good_d  = '0;
              bad_d   = '0;
              win_d   = '0;
              state_d = LOCKED;
            end else begin
              good_d = good_inc;
            end
          end
        end
        LOCKED: begin
          // Loss of lock outranks a window wrap on the same strobe.
          if (rx_sym_strobe) begin
            if (rx_sym_invalid && (bad_inc >= BAD_LIM)) begin
              state_d = HUNT;
              good_d  = '0;
              bad_d   = '0;
              win_d   = '0;
            end else if (win_inc >= WIN_LIM) begin
              bad_d = '0;
              win_d = '0;
            end else begin
              win_d = win_inc;
              if (rx_sym_invalid) begin
                bad_d = bad_inc;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = '0;
          bad_d   = '0;
          win_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pcs_d = NOT_OK;
    loc_d = 1'b0;
    if ((state_d == LOCKED) && !act_expire) begin
      pcs_d = OK;
      loc_d = 1'b1;
    end
  end

  assign pcs_status      = pcs_q;
  assign loc_rcv_status  = loc_q;
  assign rx_status_state = state_q;

`ifdef simulate
  logic [8*6-1:0] state_ascii;
  logic [8*6-1:0] pcs_ascii;

  always_comb begin
    state_ascii = "UNUSED";
    unique case (state_q)
      HUNT:    state_ascii = "HUNT  ";
      CHECK:   state_ascii = "CHECK ";
      LOCKED:  state_ascii = "LOCKED";
      default: state_ascii = "UNUSED";
    endcase
    pcs_ascii = (pcs_q == OK) ? "OK    " : "NOT_OK";
  end
`endif

endmodule

// File: tb/tb_mod_147_rx_status.sv
// Randomized scoreboard bench for mod_147_rx_status.
// A queue-based window model predicts outputs; a monitor compares every cycle.
module tb_mod_147_rx_status;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pma_reset = 1'b0;
  logic       link_control = 1'b0;
  logic       rx_sym_strobe = 1'b0;
  logic       rx_sym_invalid = 1'b0;
  logic       pcs_status;
  logic       loc_rcv_status;
  logic [1:0] rx_status_state;

  mod_147_rx_status dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pma_reset       (pma_reset),
    .link_control    (link_control),
    .rx_sym_strobe   (rx_sym_strobe),
    .rx_sym_invalid  (rx_sym_invalid),
    .pcs_status      (pcs_status),
    .loc_rcv_status  (loc_rcv_status),
    .rx_status_state (rx_status_state)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  string phase = "reset";

  logic [3:0] exp_q[$];

  bit rst_drv = 1'b0;
  bit pma_drv = 1'b0;
  bit lc_drv  = 1'b0;

  // Reference model: mode 0/1/2 = hunting / counting / locked.
  int m_mode = 0;
  int m_run  = 0;
  int m_idle = 0;
  bit m_win[$];

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s [%s] t=%0t got=%b want=%b", nm, phase, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [3:0] m_out();
    logic lk;
    lk = (m_mode == 2);
    return {~lk, lk, 2'(m_mode)};
  endfunction

  task automatic m_hunt();
    m_mode = 0;
    m_run  = 0;
    m_win.delete();
  endtask

  task automatic m_step();
    int errs;
    if (!reset_n || pma_reset || link_control) begin
      m_hunt();
      m_idle = 0;
    end else begin
      if (rx_sym_strobe) m_idle = 0;
      else if (m_idle < 1024) m_idle++;
      if (m_idle == 1024) begin
        m_hunt();
      end else if (rx_sym_strobe) begin
        if (m_mode == 2) begin
          m_win.push_back(rx_sym_invalid);
          errs = 0;
          foreach (m_win[i]) errs += int'(m_win[i]);
          if (errs >= 4) m_hunt();
          else if (m_win.size() == 64) m_win.delete();
        end else if (rx_sym_invalid) begin
          m_hunt();
        end else begin
          m_run++;
          if (m_run >= 16) begin
            m_mode = 2;
            m_run  = 0;
            m_win.delete();
          end else begin
            m_mode = 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(bit s, bit inv);
    @(negedge clk);
    reset_n        = rst_drv;
    pma_reset      = pma_drv;
    link_control   = lc_drv;
    rx_sym_strobe  = s;
    rx_sym_invalid = s ? inv : 1'($urandom_range(1, 0));
    m_step();
    exp_q.push_back(m_out());
  endtask

  task automatic sym(bit inv, int gap);
    cyc(1'b1, inv);
    repeat (gap) cyc(1'b0, 1'b0);
  endtask

  task automatic valid_run(int n, int gap);
    repeat (n) sym(1'b0, gap);
  endtask

  task automatic window(int k);
    logic [63:0] mask;
    mask = '0;
    while ($countones(mask) < k) mask[$urandom_range(63, 0)] = 1'b1;
    for (int i = 0; i < 64; i++) sym(mask[i], $urandom_range(2, 0));
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", {pcs_status, loc_rcv_status, rx_status_state}, e);
      end
    end
  end

  initial begin : stim
    #1 reset_n = 1'b0;
    #1 chk("reset_value", {pcs_status, loc_rcv_status, rx_status_state}, 4'b1000);
    repeat (3) cyc(1'b0, 1'b0);
    rst_drv = 1'b1;

    phase = "lock16";
    valid_run(16, 3);
    repeat (4) cyc(1'b0, 1'b0);

    phase = "interrupted";
    rst_drv = 1'b0;
    cyc(1'b0, 1'b0);
    rst_drv = 1'b1;
    valid_run(10, 1);
    sym(1'b1, 1);
    valid_run(16, 1);

    phase = "windows3";
    repeat (5) window(3);
    phase = "window4";
    window(4);

    phase = "timeout";
    valid_run(16, 0);
    repeat (1030) cyc(1'b0, 1'b0);
    sym(1'b0, 2);

    phase = "disable";
    pma_drv = 1'b1;
    cyc(1'b0, 1'b0);
    pma_drv = 1'b0;
    lc_drv  = 1'b1;
    repeat (50) sym(1'b0, 1);
    lc_drv = 1'b0;
    valid_run(16, 1);

    phase = "wrap_4th";
    repeat (60) sym(1'b0, 0);
    repeat (4) sym(1'b1, 0);
    sym(1'b0, 1);

    phase = "async";
    valid_run(16, 0);
    @(posedge clk);
    #3;
    chk("pre_async", {pcs_status, loc_rcv_status, rx_status_state}, m_out());
    reset_n = 1'b0;
    rst_drv = 1'b0;
    #1 chk("async_drop", {pcs_status, loc_rcv_status, rx_status_state}, 4'b1000);
    m_hunt();
    m_idle = 0;
    repeat (2) cyc(1'b1, 1'b0);
    rst_drv = 1'b1;

    phase = "soak";
    for (int i = 0; i < 1500; i++) begin
      pma_drv = ($urandom_range(199, 0) == 0);
      cyc(1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0));
    end
    pma_drv = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("drain", 4'(exp_q.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
